// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory address and
// the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Next PC: a redirect wins over stall; otherwise hold or advance sequentially.
  always_comb begin
    pc_d = pc_plus4;
    if (redirect_valid) begin
      pc_d = {redirect_target[31:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  // Next IF/ID contents: a redirect discards the wrong-path word as a bubble.
  always_comb begin
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    valid_d = valid_q;
    count_d = count_q;
    if (flush || redirect_valid) begin
      instr_d = NOP_INSTR;
      ipc_d   = 32'd0;
      ipc4_d  = 32'd0;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = imem_data;
      ipc_d   = pc_q;
      ipc4_d  = pc_plus4;
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
    end
  end

  // State registers; reset overrides every other control on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= {RESET_PC[31:2], 2'b00};
      instr_q <= NOP_INSTR;
      ipc_q   <= 32'd0;
      ipc4_q  <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_addr     = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc       = ipc_q;
  assign ifid_pc_plus4 = ipc4_q;
  assign ifid_valid    = valid_q;
  assign fetch_count   = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, then randomized traffic
// checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr, imem_data;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4, fetch_count;
  logic        ifid_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Combinational instruction memory.
  assign imem_data = word_at(imem_addr);

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid), .fetch_count(fetch_count)
  );

  typedef struct {
    logic        rst, stall, flush, rv;
    logic [31:0] tgt;
    logic [31:0] pc, ipc;
    logic        valid;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [31:0] pc, input logic [31:0] ipc,
                           input logic valid, input logic [31:0] cnt);
    logic [31:0] e_instr, e_p4, e_ipc;
    e_ipc   = valid ? ipc : 32'd0;
    e_instr = valid ? word_at(ipc) : NOP;
    e_p4    = valid ? ipc + 32'd4 : 32'd0;
    check("imem_addr", idx, imem_addr, pc);
    check("ifid_pc", idx, ifid_pc, e_ipc);
    check("ifid_instr", idx, ifid_instr, e_instr);
    check("ifid_pc_plus4", idx, ifid_pc_plus4, e_p4);
    check("ifid_valid", idx, {31'd0, ifid_valid}, {31'd0, valid});
    check("fetch_count", idx, fetch_count, cnt);
  endtask

  task automatic apply(input logic r, input logic s, input logic f, input logic v, input logic [31:0] t);
    @(negedge clk);
    rst = r; stall = s; flush = f; redirect_valid = v; redirect_target = t;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model state
  logic [31:0] m_pc, m_ipc, m_cnt;
  logic        m_valid;

  task automatic model_step(input logic r, input logic s, input logic f, input logic v, input logic [31:0] t);
    if (r) begin
      m_pc = 32'd0; m_ipc = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
    end else begin
      if (f || v) begin
        m_valid = 1'b0; m_ipc = 32'd0;
      end else if (!s) begin
        m_valid = 1'b1; m_ipc = m_pc; m_cnt = m_cnt + 1;
      end
      if (v)       m_pc = t & ~32'd3;
      else if (!s) m_pc = m_pc + 4;
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    //            rst  stl  fl   rv   target         pc             ifid_pc        v    cnt
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,         32'h0,         1'b0,32'd0};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h4,         32'h0,         1'b1,32'd1};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h8,         32'h4,         1'b1,32'd2};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        32'h8,         32'h4,         1'b1,32'd2};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        32'h8,         32'h4,         1'b1,32'd2};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        32'h8,         32'h4,         1'b1,32'd2};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'hC,         32'h8,         1'b1,32'd3};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h10,        32'hC,         1'b1,32'd4};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,32'h40,       32'h40,        32'h0,         1'b0,32'd4};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h44,        32'h40,        1'b1,32'd5};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h48,        32'h44,        1'b1,32'd6};
    vecs[11] = '{1'b0,1'b1,1'b1,1'b0,32'h0,        32'h48,        32'h0,         1'b0,32'd6};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h4C,        32'h48,        1'b1,32'd7};
    vecs[13] = '{1'b0,1'b1,1'b0,1'b1,32'h13,       32'h10,        32'h0,         1'b0,32'd7};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h14,        32'h10,        1'b1,32'd8};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b1,32'hFFFFFFFE, 32'hFFFFFFFC,  32'h0,         1'b0,32'd8};
    vecs[16] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         32'hFFFFFFFC,  1'b1,32'd9};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h4,         32'h0,         1'b1,32'd10};
    vecs[18] = '{1'b0,1'b0,1'b1,1'b0,32'h0,        32'h8,         32'h0,         1'b0,32'd10};
    vecs[19] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'hC,         32'h8,         1'b1,32'd11};
    vecs[20] = '{1'b1,1'b1,1'b1,1'b1,32'h80,       32'h0,         32'h0,         1'b0,32'd0};
    vecs[21] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h4,         32'h0,         1'b1,32'd1};

    for (int i = 0; i < 22; i++) begin
      apply(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].rv, vecs[i].tgt);
      check_all(i, vecs[i].pc, vecs[i].ipc, vecs[i].valid, vecs[i].cnt);
    end

    // Randomized traffic against the model, starting from a fresh reset.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check_all(1000, m_pc, m_ipc, m_valid, m_cnt);
    for (int i = 0; i < 400; i++) begin
      logic r, s, f, v;
      logic [31:0] t;
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 2))
        0: t = $urandom;
        1: t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        default: t = $urandom & 32'hFF;
      endcase
      apply(r, s, f, v, t);
      model_step(r, s, f, v, t);
      check_all(1001 + i, m_pc, m_ipc, m_valid, m_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
